// File: rtl/float_to_twos.sv
// rtl/float_to_twos.sv - iterative 8-bit float to two's-complement decoder
//
// Converts {sign, exp, sig} into (-1)^sign * sig * 2^exp as an OUT_W-bit
// two's-complement value, shifting the significand left one place per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_float   {sign, exp[EXP_W-1:0], sig[SIG_W-1:0]}
//   in_valid   in_float is valid
//   in_ready   block is idle and can accept an input
//   out_data   two's-complement result
//   out_valid  out_data is valid
//   out_ready  consumer accepts out_data
//   busy       conversion in progress (not idle)

module float_to_twos #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+SIG_W:0]   in_float,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        NEG   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [OUT_W-1:0]   acc;
    logic [EXP_W-1:0]   cnt;
    logic               sgn;

    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= {{(OUT_W-SIG_W){1'b0}}, in_float[SIG_W-1:0]};
                        cnt   <= in_float[SIG_W +: EXP_W];
                        sgn   <= in_float[EXP_W+SIG_W];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cnt holds the remaining exponent; one doubling per clock.
                    if (cnt == '0) begin
                        state <= NEG;
                    end else begin
                        acc <= acc << 1;
                        cnt <= cnt - EXP_W'(1);
                    end
                end
                NEG: begin
                    // Negating a zero accumulator gives zero, so no -0 appears.
                    out_data  <= sgn ? (~acc + OUT_W'(1)) : acc;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // out_data is left untouched; only the handshake clears valid.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_twos.sv
// tb/tb_float_to_twos.sv - scoreboard testbench for float_to_twos

module tb_float_to_twos;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_float;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [11:0] exp_q[$];
    logic        stream_done;

    float_to_twos #(.EXP_W(3), .SIG_W(4), .OUT_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_float  (in_float),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, need completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    // Reference value computed arithmetically, independent of shift order.
    function automatic logic [11:0] model(input logic [7:0] f);
        int v;
        v = int'(f[3:0]) * (1 << f[6:4]);
        if (f[7]) v = -v;
        return 12'(v);
    endfunction

    // Scoreboard monitor: one compare per output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL sb_extra: got output %0h, need no output", out_data);
            end else begin
                check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] f, input logic [11:0] expv);
        int t = 0;
        in_float = f;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("accept_timeout", 32'd1, 32'd0);
        exp_q.push_back(expv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_float = 8'($urandom);
    endtask

    // Counts clocks from the accept edge until out_valid is seen.
    task automatic latency(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        rst         = 1'b1;
        in_float    = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        stream_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 1: E=0, latency 2, valid for one cycle
        send(8'h05, 12'h005);
        latency(cyc);
        check("lat_e0", 32'(cyc), 32'd2);
        @(posedge clk); #1;
        check("valid_width", 32'(out_valid), 32'd0);
        drain();

        // 2: E=7 extremes
        send(8'h7F, 12'h780);
        latency(cyc);
        check("lat_e7", 32'(cyc), 32'd9);
        drain();
        send(8'hFF, 12'h880);
        drain();

        // 3: negative values and signed zero
        send(8'hB9, 12'hFB8);
        send(8'hF0, 12'h000);
        send(8'h80, 12'h000);
        drain();

        // 4: backpressure
        out_ready = 1'b0;
        send(8'h35, 12'h028);
        latency(cyc);
        in_float = 8'h12;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'h028);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("bp_hs_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        send(8'h12, 12'h004);
        drain();

        // 5: reset during SHIFT cycle 3 discards the conversion
        send(8'h6F, 12'h000);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        send(8'h12, 12'h004);
        drain();

        // 6: all 256 codes with random gaps and random backpressure
        fork
            begin
                for (int c = 0; c < 256; c++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(8'(c), model(8'(c)));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
